// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte producers.
// Grants one requester, latches its byte and the frame configuration, pulses
// tx_start/ack for one cycle, then holds off further grants for one full frame
// plus a guard bit.
module uart_tx_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic              dnum,
  input  logic              snum,
  input  logic [1:0]        par,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    grant_id,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              tx_dnum,
  output logic              tx_snum,
  output logic [1:0]        tx_par,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StStart, StHold} state_e;

  state_e          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [3:0]      cnt_q;

  logic [IDW:0]    start_pos;
  logic [IDW:0]    win_off;
  logic [IDW:0]    win_pos;
  logic [2*NREQ-1:0] req_dbl;
  logic            win_valid;
  logic [IDW-1:0]  win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [7:0]      win_byte;
  logic            grant;
  logic            par_on;
  logic [3:0]      flen;

  // Round-robin search: rotate requests so ptr+1 sits at bit 0, take the lowest set bit.
  always_comb begin
    start_pos = {1'b0, ptr_q} + 1'b1;
    if (start_pos == (IDW+1)'(NREQ)) begin
      start_pos = '0;
    end
    req_dbl   = {req, req} >> start_pos;
    win_valid = 1'b0;
    win_off   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_dbl[j]) begin
        win_valid = 1'b1;
        win_off   = (IDW+1)'(j);
      end
    end
    win_pos = start_pos + win_off;
    if (win_pos >= (IDW+1)'(NREQ)) begin
      win_pos = win_pos - (IDW+1)'(NREQ);
    end
    win_idx = win_pos[IDW-1:0];
  end

  // Decode the winner into a one-hot ack pattern and select its byte.
  always_comb begin
    win_onehot = '0;
    win_byte   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        win_onehot[i] = 1'b1;
        win_byte      = req_data[8*i +: 8];
      end
    end
  end

  // Grant is suppressed during reset so busy reads as its reset value.
  assign grant    = (state_q == StIdle) & en & win_valid & ~rst;
  assign busy     = (state_q != StIdle) | grant;
  assign grant_id = ptr_q;

  // Frame length from the latched configuration only: start + data + parity + stop + guard.
  always_comb begin
    par_on = (tx_par == 2'b01) | (tx_par == 2'b10);
    flen   = 4'd2 + (tx_dnum ? 4'd8 : 4'd7) + {3'b000, par_on} + (tx_snum ? 4'd2 : 4'd1);
  end

  // Scheduler FSM with registered start/ack pulses and latched frame parameters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= IDW'(NREQ - 1);
      cnt_q    <= '0;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      tx_dnum  <= 1'b0;
      tx_snum  <= 1'b0;
      tx_par   <= '0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            ptr_q    <= win_idx;
            tx_data  <= win_byte;
            tx_dnum  <= dnum;
            tx_snum  <= snum;
            tx_par   <= par;
            ack      <= win_onehot;
            tx_start <= 1'b1;
            state_q  <= StStart;
          end
        end
        StStart: begin
          cnt_q   <= flen - 4'd1;
          state_q <= StHold;
        end
        StHold: begin
          if (cnt_q == 4'd0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: each test pushes the grants it expects,
// a negedge monitor pops and compares them whenever tx_start pulses.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic              dnum;
  logic              snum;
  logic [1:0]        par;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    grant_id;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_dnum;
  logic              tx_snum;
  logic [1:0]        tx_par;
  logic              busy;

  uart_tx_scheduler #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .req_data (req_data),
    .dnum     (dnum),
    .snum     (snum),
    .par      (par),
    .ack      (ack),
    .grant_id (grant_id),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_dnum  (tx_dnum),
    .tx_snum  (tx_snum),
    .tx_par   (tx_par),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int dnum;
    int snum;
    int par;
    int gap;  // expected tx_start spacing from the previous start, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   last_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int flen_of(input int d, input int s, input int p);
    return 1 + (d != 0 ? 8 : 7) + ((p == 1 || p == 2) ? 1 : 0) + (s != 0 ? 2 : 1) + 1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int id, input int data, input int d, input int s, input int p,
                      input int gap);
    exp_t e;
    e.id = id; e.data = data; e.dnum = d; e.snum = s; e.par = p; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    tick(2);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input int maxc);
    int k;
    k = 0;
    while (sb.size() != 0 && k < maxc) begin
      tick(1);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      tick(1);
      k++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_dnum"}, tx_dnum, 0);
    check({tag, "_tx_snum"}, tx_snum, 0);
    check({tag, "_tx_par"}, tx_par, 0);
    check({tag, "_grant_id"}, grant_id, NREQ - 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every start pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (tx_start) begin
        if (sb.size() == 0) begin
          check("unexpected_start", 1, 0);
        end else begin
          e = sb.pop_front();
          check("grant_id", grant_id, e.id);
          check("ack_onehot", ack, 32'd1 << e.id);
          check("tx_data", tx_data, e.data);
          check("tx_dnum", tx_dnum, e.dnum);
          check("tx_snum", tx_snum, e.snum);
          check("tx_par", tx_par, e.par);
          if (e.gap != 0) check("spacing", cyc - last_start, e.gap);
        end
        last_start = cyc;
      end else begin
        check("ack_quiet", ack, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp = 0; n_bad = 0; cyc = 0; last_start = 0;
    rst = 1'b1; en = 1'b0; req = '0; req_data = '0;
    dnum = 1'b0; snum = 1'b0; par = 2'b00;
    tick(3);
    check_reset_values("rst");
    rst = 1'b0;
    tick(1);

    // Single request, 8N1.
    en = 1'b1; dnum = 1'b1; snum = 1'b0; par = 2'b00;
    req_data = 32'h0000_00A5; req = 4'b0001;
    push(0, 'hA5, 1, 0, 0, 0);
    #1 check("busy_mealy", busy, 1);
    tick(1);
    check("single_latency", tx_start, 1);
    req = '0;
    n = 0;
    while (busy && n < 40) begin
      tick(1);
      n++;
    end
    check("single_idle_after", n, flen_of(1, 0, 0) + 1);

    // Round robin over four held requests, 8N1.
    do_reset();
    en = 1'b1; dnum = 1'b1; snum = 1'b0; par = 2'b00;
    req_data = 32'h4433_2211; req = 4'b1111;
    n = flen_of(1, 0, 0) + 2;
    push(0, 'h11, 1, 0, 0, 0);
    push(1, 'h22, 1, 0, 0, n);
    push(2, 'h33, 1, 0, 0, n);
    push(3, 'h44, 1, 0, 0, n);
    push(0, 'h11, 1, 0, 0, n);
    wait_drain(100);
    req = '0;
    wait_idle(40);

    // Config latch: 8O2 frame, config changed during HOLD.
    do_reset();
    en = 1'b1; dnum = 1'b1; snum = 1'b1; par = 2'b01;
    req_data = 32'h0000_005A; req = 4'b0001;
    push(0, 'h5A, 1, 1, 1, 0);
    push(0, 'h5A, 1, 0, 0, flen_of(1, 1, 1) + 2);
    push(0, 'h5A, 1, 0, 0, flen_of(1, 0, 0) + 2);
    n = 0;
    while (sb.size() > 2 && n < 40) begin
      tick(1);
      n++;
    end
    check("cfg_first_start", sb.size(), 2);
    tick(3);
    par = 2'b00; snum = 1'b0;
    wait_drain(100);
    req = '0;
    wait_idle(40);

    // Enable gating.
    do_reset();
    en = 1'b0; dnum = 1'b0; snum = 1'b0; par = 2'b10;
    req_data = 32'h00C3_0000; req = 4'b0100;
    n = 0;
    repeat (20) begin
      tick(1);
      if (tx_start || ack != '0 || busy) n++;
    end
    check("gate_quiet", n, 0);
    en = 1'b1;
    push(2, 'hC3, 0, 0, 2, 0);
    tick(1);
    check("en_latency", tx_start, 1);
    req = '0;
    wait_idle(40);

    // Mid-frame reset in HOLD cycle 5.
    do_reset();
    en = 1'b1; dnum = 1'b1; snum = 1'b0; par = 2'b00;
    req_data = 32'h0000_7E69; req = 4'b0001;
    push(0, 'h69, 1, 0, 0, 0);
    tick(1);
    check("mr_start", tx_start, 1);
    tick(5);
    rst = 1'b1; req = 4'b0010;
    tick(1);
    check_reset_values("mr");
    rst = 1'b0;
    sb.delete();
    push(1, 'h7E, 1, 0, 0, 0);
    tick(1);
    check("mr_restart", tx_start, 1);
    req = '0;
    wait_idle(40);

    // Request withdrawn right after its grant.
    do_reset();
    en = 1'b1; dnum = 1'b0; snum = 1'b1; par = 2'b00;
    req_data = 32'hE700_0000; req = 4'b1000;
    push(3, 'hE7, 0, 1, 0, 0);
    tick(1);
    req = '0; req_data = '0;
    check("wd_start", tx_start, 1);
    check("wd_ack", ack, 4'b1000);
    tick(4);
    check("wd_data_hold", tx_data, 'hE7);
    check("wd_busy", busy, 1);
    wait_idle(40);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
